// File: rtl/teller_dispatcher.sv
// teller_dispatcher: calls the head-of-queue customer to a free, staffed teller window
// in round-robin order and keeps track of which tellers are serving a customer.
//
// Ports:
//   clk1     in   system clock, rising edge
//   rst1     in   asynchronous active-low reset
//   pcount   in   queue occupancy from the person counter (0-7)
//   tenable  in   teller staffed flags, bit i = teller i
//   tdone    in   one-cycle "customer finished" pulse per teller
//   out1     out  one-cycle dequeue pulse to the person counter
//   tcall    out  one-hot call to the granted teller, coincident with out1
//   tbusy    out  teller i is serving a customer
//   Tcount   out  staffed-teller count for the waiting-time ROM, saturated to 1-3
//   nostaff  out  no teller is staffed
module teller_dispatcher #(
  parameter int unsigned HOLD_CYCLES = 1  // 1-7
) (
  input  logic       clk1,
  input  logic       rst1,
  input  logic [2:0] pcount,
  input  logic [2:0] tenable,
  input  logic [2:0] tdone,
  output logic       out1,
  output logic [2:0] tcall,
  output logic [2:0] tbusy,
  output logic [1:0] Tcount,
  output logic       nostaff
);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e     r_state;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_winner;
  logic [2:0] r_hold_cnt;

  logic [2:0] w_free;
  logic [1:0] w_start;
  logic [1:0] w_cand [3];
  logic [1:0] w_winner;
  logic       w_found;
  logic [1:0] w_pop;
  logic [2:0] w_busy_next;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Teller is free when staffed and idle; a same-cycle tdone does not count yet.
  assign w_free  = tenable & ~tbusy;
  assign w_start = inc3(r_rr_ptr);

  always_comb begin
    w_cand[0] = w_start;
    w_cand[1] = inc3(w_start);
    w_cand[2] = inc3(w_cand[1]);
    w_found   = 1'b0;
    w_winner  = 2'd0;
    // Scan lowest priority first so the highest-priority free teller is written last.
    for (int i = 2; i >= 0; i--) begin
      if (w_free[w_cand[i]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[i];
      end
    end
  end

  assign w_pop = {1'b0, tenable[0]} + {1'b0, tenable[1]} + {1'b0, tenable[2]};

  // tdone clears independently; a grant sets its teller on the edge leaving GRANT.
  always_comb begin
    w_busy_next = tbusy & ~tdone;
    if (r_state == StGrant) begin
      w_busy_next = w_busy_next | (3'b001 << r_winner);
    end
  end

  always_ff @(posedge clk1 or negedge rst1) begin
    if (!rst1) begin
      r_state    <= StIdle;
      r_rr_ptr   <= 2'd2;
      r_winner   <= 2'd0;
      r_hold_cnt <= 3'd0;
      out1       <= 1'b0;
      tcall      <= 3'b000;
      tbusy      <= 3'b000;
      Tcount     <= 2'd1;
      nostaff    <= 1'b1;
    end else begin
      Tcount  <= (w_pop == 2'd0) ? 2'd1 : w_pop;
      nostaff <= (tenable == 3'b000);
      tbusy   <= w_busy_next;
      case (r_state)
        StIdle: begin
          // Never dequeue from an empty queue.
          if ((pcount != 3'd0) && w_found) begin
            r_winner <= w_winner;
            out1     <= 1'b1;
            tcall    <= 3'b001 << w_winner;
            r_state  <= StGrant;
          end
        end
        StGrant: begin
          out1       <= 1'b0;
          tcall      <= 3'b000;
          r_rr_ptr   <= r_winner;
          r_hold_cnt <= 3'd0;
          r_state    <= StHold;
        end
        StHold: begin
          // Give the person counter time to settle before the next decision.
          if (r_hold_cnt == 3'(HOLD_CYCLES - 1)) begin
            r_hold_cnt <= 3'd0;
            r_state    <= StIdle;
          end else begin
            r_hold_cnt <= r_hold_cnt + 3'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_teller_dispatcher.sv
// Bench for teller_dispatcher: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-level reference model.
module tb_teller_dispatcher;

  localparam int Hold = 1;

  logic       clk1 = 1'b0;
  logic       rst1;
  logic [2:0] pcount, tenable, tdone;
  logic       out1, nostaff;
  logic [2:0] tcall, tbusy;
  logic [1:0] Tcount;

  teller_dispatcher #(.HOLD_CYCLES(Hold)) dut (
    .clk1   (clk1),
    .rst1   (rst1),
    .pcount (pcount),
    .tenable(tenable),
    .tdone  (tdone),
    .out1   (out1),
    .tcall  (tcall),
    .tbusy  (tbusy),
    .Tcount (Tcount),
    .nostaff(nostaff)
  );

  always #5 clk1 = ~clk1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who is serving, whose turn it is, how long until the next call.
  int   m_busy [3];
  int   m_last;     // teller that received the most recent call
  int   m_cool;     // settle cycles still to wait after a call
  int   m_pend;     // teller being called this cycle, -1 if none
  int   m_pc;       // customers waiting in the queue
  logic m_out1;
  logic [2:0] m_tcall;
  logic [1:0] m_tcount;
  logic m_nostaff;

  int pulses;       // out1 pulses seen on the DUT
  int calls0;       // calls to teller 0 seen on the DUT

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] busy_vec();
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (m_busy[i] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_busy[i] = 0;
    m_last = 2; m_cool = 0; m_pend = -1;
    m_out1 = 1'b0; m_tcall = 3'b000; m_tcount = 2'd1; m_nostaff = 1'b1;
  endtask

  task automatic model_edge(input logic [2:0] en, input logic [2:0] done, input bit arrive);
    int nb [3];
    int staffed;
    for (int i = 0; i < 3; i++) nb[i] = (m_busy[i] != 0 && !done[i]) ? 1 : 0;
    m_out1 = 1'b0;
    m_tcall = 3'b000;
    if (m_pend >= 0) begin
      // Call completes: teller starts serving, one customer leaves the queue.
      nb[m_pend] = 1;
      m_last = m_pend;
      m_pend = -1;
      m_cool = Hold;
      if (m_pc > 0) m_pc--;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (m_pc != 0) begin
      for (int k = 1; k <= 3; k++) begin
        int t;
        t = (m_last + k) % 3;
        if (en[t] && m_busy[t] == 0) begin
          m_pend = t;
          m_out1 = 1'b1;
          m_tcall[t] = 1'b1;
          break;
        end
      end
    end
    if (arrive && m_pc < 7) m_pc++;
    for (int i = 0; i < 3; i++) m_busy[i] = nb[i];
    staffed = int'(en[0]) + int'(en[1]) + int'(en[2]);
    m_tcount = (staffed == 0) ? 2'd1 : 2'(staffed);
    m_nostaff = (staffed == 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out1"}, {7'd0, out1}, {7'd0, m_out1});
    chk({tag, ".tcall"}, {5'd0, tcall}, {5'd0, m_tcall});
    chk({tag, ".tbusy"}, {5'd0, tbusy}, {5'd0, busy_vec()});
    chk({tag, ".Tcount"}, {6'd0, Tcount}, {6'd0, m_tcount});
    chk({tag, ".nostaff"}, {7'd0, nostaff}, {7'd0, m_nostaff});
  endtask

  // One clock: drive inputs, advance the model at the edge, sample 1 time unit later.
  task automatic step(input string tag, input logic [2:0] en, input logic [2:0] done,
                      input bit arrive);
    tenable = en;
    tdone   = done;
    pcount  = 3'(m_pc);
    @(posedge clk1);
    model_edge(en, done, arrive);
    #1;
    if (out1 === 1'b1) pulses++;
    if (tcall[0] === 1'b1) calls0++;
    check_all(tag);
    tdone = 3'b000;
  endtask

  task automatic do_reset(input int pc);
    rst1 = 1'b0;
    #1;
    model_reset();
    m_pc = pc;
    pcount = 3'(pc);
    check_all("reset");
    @(posedge clk1);
    #1;
    rst1 = 1'b1;
  endtask

  initial begin
    rst1 = 1'b0; pcount = 3'd0; tenable = 3'b000; tdone = 3'b000;
    pulses = 0; calls0 = 0;
    model_reset();
    m_pc = 0;
    @(posedge clk1);
    #1;

    // 1: reset values, nothing staffed, empty queue.
    do_reset(0);
    for (int i = 0; i < 6; i++) step("idle", 3'b000, 3'b000, 1'b0);

    // 2: round-robin fill of three tellers from a queue of five.
    do_reset(5);
    pulses = 0;
    for (int i = 0; i < 14; i++) step("fill", 3'b111, 3'b000, 1'b0);
    chk("fill.pulses", 8'(pulses), 8'd3);
    chk("fill.tbusy", {5'd0, tbusy}, 8'h07);

    // 3: release teller 1 then tellers 0 and 2.
    step("rel1", 3'b111, 3'b010, 1'b0);
    chk("rel1.tbusy", {5'd0, tbusy}, 8'h05);
    step("rel1.idle", 3'b111, 3'b000, 1'b0);
    chk("rel1.call", {5'd0, tcall}, 8'h02);
    for (int i = 0; i < 4; i++) step("rel1.wait", 3'b111, 3'b000, 1'b1);
    step("rel02", 3'b111, 3'b101, 1'b0);
    for (int i = 0; i < 10; i++) step("rel02.run", 3'b111, 3'b000, 1'b0);

    // 4: empty queue with everyone free, then one customer.
    do_reset(0);
    pulses = 0;
    for (int i = 0; i < 20; i++) step("empty", 3'b111, 3'b000, 1'b0);
    chk("empty.pulses", 8'(pulses), 8'd0);
    step("one", 3'b111, 3'b000, 1'b1);
    for (int i = 0; i < 10; i++) step("one.run", 3'b111, 3'b000, 1'b0);
    chk("one.pulses", 8'(pulses), 8'd1);
    chk("one.tbusy", {5'd0, tbusy}, 8'h01);

    // 5: teller 0 unstaffed while busy.
    do_reset(6);
    for (int i = 0; i < 10; i++) step("dis.fill", 3'b111, 3'b000, 1'b0);
    calls0 = 0;
    step("dis.drop", 3'b110, 3'b000, 1'b0);
    chk("dis.Tcount", {6'd0, Tcount}, 8'h02);
    for (int i = 0; i < 4; i++) step("dis.hold", 3'b110, 3'b000, 1'b0);
    chk("dis.busy0", {7'd0, tbusy[0]}, 8'h01);
    step("dis.done0", 3'b110, 3'b001, 1'b0);
    for (int i = 0; i < 4; i++) step("dis.after", 3'b110, 3'b000, 1'b0);
    step("dis.done12", 3'b110, 3'b110, 1'b0);
    for (int i = 0; i < 12; i++) step("dis.run", 3'b110, 3'b000, 1'b1);
    chk("dis.calls0", 8'(calls0), 8'd0);

    // 6: reset asserted in the middle of a GRANT cycle.
    do_reset(2);
    begin
      int n;
      n = 0;
      while (m_pend < 0 && n < 10) begin
        step("mid.wait", 3'b111, 3'b000, 1'b0);
        n++;
      end
      chk("mid.reached", {7'd0, m_pend >= 0}, 8'h01);
    end
    #2;
    rst1 = 1'b0;
    #1;
    chk("mid.out1", {7'd0, out1}, 8'h00);
    chk("mid.tcall", {5'd0, tcall}, 8'h00);
    chk("mid.tbusy", {5'd0, tbusy}, 8'h00);
    model_reset();
    m_pc = 2;
    @(posedge clk1);
    #1;
    rst1 = 1'b1;
    step("mid.dec", 3'b111, 3'b000, 1'b0);
    chk("mid.first", {5'd0, tcall}, 8'h01);
    for (int i = 0; i < 6; i++) step("mid.run", 3'b111, 3'b000, 1'b0);

    // Randomized traffic.
    begin
      logic [2:0] en;
      en = 3'b111;
      for (int i = 0; i < 400; i++) begin
        logic [2:0] dn;
        if ($urandom_range(0, 15) == 0) en = 3'($urandom_range(0, 7));
        dn = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        step("rand", en, dn, ($urandom_range(0, 2) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/teller_dispatcher.md
# teller_dispatcher

Queue-to-teller dispatcher for the bank queue system. It watches the customer-count output of the queue's up/down person counter and the state of up to three teller windows, and calls the head-of-queue customer to a free, staffed teller using round-robin order. It drives the counter's dequeue input (`out1`) and supplies the staffed-teller count (`Tcount`) used by the waiting-time ROM.

## Interface

Parameters:
- `HOLD_CYCLES`, default 1: cycles spent in HOLD after each grant so `pcount` can settle; legal range 1-7.

Ports:
- `clk1`  in  1  system clock; all state changes on the rising edge.
- `rst1`  in  1  reset, asynchronous, active-low.
- `pcount`  in  3  current queue occupancy from the person counter (0-7).
- `tenable`  in  3  teller staffed flags; bit i is teller i.
- `tdone`  in  3  one-cycle pulse from teller i: customer finished.
- `out1`  out  1  one-cycle dequeue pulse to the person counter.
- `tcall`  out  3  one-hot call to the granted teller; high in the same cycle as `out1`.
- `tbusy`  out  3  teller i is serving a customer.
- `Tcount`  out  2  number of staffed tellers for the ROM, saturated to the range 1-3.
- `nostaff`  out  1  high when `tenable == 3'b000`.

## Operation

- Teller i is free when `tenable[i] && !tbusy[i]`.
- **FSM states:** IDLE, GRANT, HOLD.
  - **IDLE:** if `pcount != 0` and any teller is free, latch the winner and go to GRANT. Otherwise stay in IDLE.
  - **GRANT (1 cycle):**
    - Assert `out1 = 1` and set `tcall[w] = 1` for winner w.
    - `tbusy[w]` goes high on the edge leaving GRANT.
    - Set `rr_ptr = w`, then go to HOLD.
  - **HOLD:** count `HOLD_CYCLES` cycles, then return to IDLE.
- **Round-robin:** search free tellers starting at `(rr_ptr+1) mod 3`, ascending with wrap. Reset value of `rr_ptr` is 2, so teller 0 has first priority after reset.
- **Arbitration inputs:** the winner is computed from `tbusy`/`tenable` as registered at the start of the IDLE cycle.
- **tdone handling:**
  - `tdone[i]` clears `tbusy[i]` on the next edge.
  - `tdone` on a non-busy teller is ignored.
  - Multiple `tdone` bits may be set together; each clears independently.
- **Disable while busy:** `tenable[i]` falling while `tbusy[i]` is set does not clear `tbusy[i]`. The teller finishes its customer and is then not granted again.
- **Tcount:** registered popcount of `tenable`.
  - If the popcount is 0, `Tcount = 2'b01` and `nostaff = 1`.
  - This keeps the ROM index `Tcount-1` in range.
- **pcount == 0:** never assert `out1`. The counter must not underflow.
- **Enable drops between decision and grant:** the grant is still issued if the winner's `tenable` falls after the IDLE decision.
- **Reset mid-operation:** every output and all internal state return to reset values immediately, including during GRANT. An `out1` pulse truncated by reset is not reissued.

## Timing

- Reset values:
  - `out1 = 0`, `tcall = 3'b000`, `tbusy = 3'b000`
  - `Tcount = 2'b01`, `nostaff = 1`
  - state = IDLE, `rr_ptr = 2`, hold counter = 0
- All outputs are registered; there are no combinational paths from input to output.
- **Grant latency:**
  - Decision in IDLE cycle n, then `out1`/`tcall` high in cycle n+1 only.
  - `tbusy[w]` high from cycle n+2.
- **Grant spacing:** minimum 2 + `HOLD_CYCLES` cycles between successive `out1` pulses, which is 3 at the default.
- **Tcount / nostaff:** update one cycle after a `tenable` change.
- **tdone to re-grant:** `tdone[i]` in cycle k makes teller i free from cycle k+1. If in IDLE at k+1, a grant to i appears at k+2 at the earliest.
- **Same-cycle tdone and grant:** if `tdone[i]` coincides with an IDLE decision, teller i is not a candidate in that decision.

## Test plan

1. **Reset values:** hold `rst1 = 0`, then release with `tenable = 3'b000`, `pcount = 0` -> `Tcount = 1`, `nostaff = 1`, `out1 = 0`, `tbusy = 0` indefinitely.
2. **Round-robin fill:** `tenable = 3'b111`, `pcount = 5`, no `tdone` -> grants to teller 0, 1, 2 at 3-cycle spacing with exactly 3 `out1` pulses. Final `tbusy = 3'b111`, then no further grants.
3. **Wrap and release:** continue from scenario 2, pulse `tdone = 3'b010` -> `tbusy = 3'b101` next cycle, grant to teller 1 two cycles after the pulse, `rr_ptr = 1`. Then pulse `tdone = 3'b101` -> next grant goes to teller 2, then teller 0.
4. **Empty queue:** `pcount = 0`, `tenable = 3'b111`, all free -> no `out1` for 20 cycles. Then `pcount = 1` -> exactly one grant (to teller 0).
5. **Disable while busy:** teller 0 busy, drop `tenable[0]`, with `pcount = 3` -> `tbusy[0]` stays 1 until `tdone[0]`, then clears. Teller 0 is never granted again and `Tcount` goes 3 -> 2 one cycle after the drop.
6. **Reset mid-grant:** assert `rst1 = 0` during the GRANT cycle -> `out1`, `tcall` and `tbusy` go to 0 immediately. After release the first grant goes to teller 0.
